// File: rtl/mips_bus_copy_engine.sv
// rtl/mips_bus_copy_engine.sv - word-by-word memory copy engine acting as bus initiator
module mips_bus_copy_engine #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        src_addr,
  input  logic [31:0]        dst_addr,
  input  logic [COUNT_W-1:0] word_count,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] words_done,
  output logic [31:0]        address,
  output logic               read,
  output logic               write,
  input  logic               waitrequest,
  output logic [31:0]        writedata,
  output logic [3:0]         byteenable,
  input  logic [31:0]        readdata
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t             state_q;
  logic [31:0]        src_q, dst_q, address_q, data_q;
  logic [COUNT_W-1:0] count_q, words_done_q;
  logic               read_q, write_q, busy_q, done_q;
  logic [3:0]         be_q;

  logic [COUNT_W-1:0] words_done_d;
  logic [31:0]        src_d, dst_d;

  assign words_done_d = words_done_q + {{(COUNT_W-1){1'b0}}, 1'b1};
  assign src_d        = src_q + 32'd4;
  assign dst_d        = dst_q + 32'd4;

  // All bus outputs are registers, so a held stall keeps them stable for free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      address_q    <= '0;
      data_q       <= '0;
      count_q      <= '0;
      words_done_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      be_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            words_done_q <= '0;
            if (word_count != '0) begin
              src_q     <= src_addr & WORD_MASK;
              dst_q     <= dst_addr & WORD_MASK;
              count_q   <= word_count;
              address_q <= src_addr & WORD_MASK;
              read_q    <= 1'b1;
              be_q      <= 4'hF;
              busy_q    <= 1'b1;
              state_q   <= S_READ;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_READ: begin
          if (!waitrequest) begin
            data_q    <= readdata;
            read_q    <= 1'b0;
            write_q   <= 1'b1;
            address_q <= dst_q;
            state_q   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (!waitrequest) begin
            src_q        <= src_d;
            dst_q        <= dst_d;
            words_done_q <= words_done_d;
            write_q      <= 1'b0;
            if (words_done_d == count_q) begin
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              address_q <= '0;
              data_q    <= '0;
              be_q      <= '0;
              state_q   <= S_DONE;
            end else begin
              read_q    <= 1'b1;
              address_q <= src_d;
              state_q   <= S_READ;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign words_done = words_done_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = data_q;
  assign byteenable = be_q;

endmodule

// File: doc/mips_bus_copy_engine.md
MIPS_BUS_COPY_ENGINE -- requirements
Module: mips_bus_copy_engine

Interface
REQ-001 The block SHALL have parameter COUNT_W, default 16, giving the width of the word-count input and progress output.
REQ-002 The block SHALL have these ports:
  clk  input  1  sole clock, all state on rising edge
  reset  input  1  asynchronous, active-low; 0 = held in reset
  start  input  1  single-cycle request to begin a copy
  src_addr  input  32  byte address of first source word
  dst_addr  input  32  byte address of first destination word
  word_count  input  COUNT_W  number of 32-bit words to copy
  busy  output  1  copy in progress
  done  output  1  one-cycle completion pulse
  words_done  output  COUNT_W  words written so far in current/last copy
  address  output  32  bus byte address
  read  output  1  bus read request
  write  output  1  bus write request
  waitrequest  input  1  responder stall
  writedata  output  32  bus write data
  byteenable  output  4  bus byte lanes
  readdata  input  32  bus read data

Function
REQ-003 The block SHALL act as bus initiator toward a word-addressed RAM responder on the same read/write/waitrequest protocol the CPU uses.
REQ-004 The state machine SHALL have states IDLE, READ, WRITE, DONE.
REQ-005 In IDLE, start=1 at a rising edge with word_count!=0 SHALL latch src_addr, dst_addr, word_count, clear words_done, and enter READ.
REQ-006 In IDLE, start=1 with word_count==0 SHALL enter DONE directly, no bus activity, words_done=0.
REQ-007 start SHALL be ignored in READ, WRITE, DONE.
REQ-008 Address bits [1:0] of src_addr/dst_addr SHALL be forced to 0 when latched.
REQ-009 In READ: read=1, write=0, address=current source pointer, byteenable=4'b1111.
REQ-010 A read SHALL complete on a rising edge where read=1 and waitrequest=0; readdata SHALL be captured at that edge into an internal data register and the state SHALL move to WRITE.
REQ-011 While waitrequest=1, address, read, write, writedata, byteenable SHALL be held stable.
REQ-012 In WRITE: write=1, read=0, address=current destination pointer, writedata=captured data, byteenable=4'b1111.
REQ-013 A write SHALL complete on a rising edge where write=1 and waitrequest=0; both pointers SHALL then advance by 4 (modulo 2^32, wrapping 0xFFFFFFFC->0x00000000) and words_done SHALL increment.
REQ-014 After a write completion, if words_done (post-increment) equals latched word_count the state SHALL move to DONE, else to READ.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 busy SHALL be 1 exactly in READ and WRITE.
REQ-017 read and write SHALL never be 1 in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-018 With waitrequest tied 0, an N-word copy SHALL take 2N cycles in READ/WRITE plus 1 DONE cycle after the start edge.
REQ-019 words_done SHALL hold its final value in IDLE until the next accepted start.
REQ-020 Overlapping source/destination ranges SHALL be copied strictly in ascending word order, one word at a time.
REQ-021 address SHALL be 0 and writedata SHALL be 0 in IDLE and DONE.

Reset
REQ-022 While reset=0, regardless of clk: state=IDLE, busy=0, done=0, read=0, write=0, address=0, writedata=0, byteenable=0, words_done=0, internal pointers/data=0.
REQ-023 Reset asserted mid-transfer SHALL drop read/write within the same time step, abandon the copy, and issue no done pulse.
REQ-024 After reset deasserts, the block SHALL remain in IDLE until a new start.

Verification
REQ-025 Zero-wait copy: RAM words 0x100..0x10C = 1,2,3,4; start src=0x100 dst=0x200 count=4 -> 0x200..0x20C = 1,2,3,4, done pulse exactly 9 cycles after start edge, words_done=4.
REQ-026 Wait states: responder waitrequest=1 for 3 cycles per access, count=2 -> bus signals stable during stalls, data copied correctly, done after 2*2*4+1=17 cycles.
REQ-027 Zero count: start with count=0 -> done next cycle, read/write never asserted, busy stays 0.
REQ-028 Misaligned/wrap: src=0xFFFFFFFE (aligns to 0xFFFFFFFC) count=2 -> reads at 0xFFFFFFFC then 0x00000000.
REQ-029 Reset mid-copy: count=8, assert reset=0 during 3rd WRITE -> read=write=busy=0 immediately, no done, 0x208 onward untouched; new start after release runs normally.
REQ-030 Start while busy: second start pulse during copy -> ignored, original count and addresses unchanged.
